// File: rtl/branch_history_predictor_if.sv
// Fetch/writeback bus between the datapath and the dynamic branch predictor.
// The datapath drives fetch and writeback information (master). The predictor
// returns the next fetch address, the prediction, the flush and the
// performance counters (slave).
interface branch_history_predictor_if;
   // fetch stage
   logic        imem_stall;
   logic [3:0]  rom_opcode;
   logic [2:0]  nzp;
   logic [15:0] pc;
   logic [15:0] pc_inc;
   logic [15:0] adj9_out;
   logic [15:0] address_out;
   logic        predict_taken;
   // writeback stage
   logic        wb_valid;
   logic [3:0]  wb_opcode;
   logic [2:0]  wb_nzp;
   logic [15:0] wb_pc;
   logic [15:0] wb_pc_plus2;
   logic [15:0] wb_target;
   logic        wb_pred_taken;
   logic        branch_enable;
   logic        reset_sig;
   // performance counters
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   modport master (
      output imem_stall, rom_opcode, nzp, pc, pc_inc, adj9_out,
      output wb_valid, wb_opcode, wb_nzp, wb_pc, wb_pc_plus2, wb_target,
      output wb_pred_taken, branch_enable,
      input  address_out, predict_taken, reset_sig,
      input  branch_count, mispredict_count
   );

   modport slave (
      input  imem_stall, rom_opcode, nzp, pc, pc_inc, adj9_out,
      input  wb_valid, wb_opcode, wb_nzp, wb_pc, wb_pc_plus2, wb_target,
      input  wb_pred_taken, branch_enable,
      output address_out, predict_taken, reset_sig,
      output branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_history_predictor.sv
// Dynamic BR direction predictor for the LC-3b fetch stage.
// A table of saturating counters indexed by the fetch PC predicts conditional
// branches. Branches resolved at writeback train their counter, and a
// mispredict raises reset_sig (pipeline flush) and redirects fetch.
// Saturating branch and mispredict counters are provided for profiling.
module branch_history_predictor #(
   parameter int INDEX_BITS = 4,
   parameter int CTR_BITS   = 2,
   parameter int RESET_CTR  = 2
) (
   input logic                    clk,
   input logic                    reset,
   branch_history_predictor_if.slave bus
);

   localparam int                  ENTRIES  = 1 << INDEX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(RESET_CTR);
   localparam logic [3:0]          OP_BR    = 4'b0000;

   // counter table and performance counters
   logic [CTR_BITS-1:0] table_q [ENTRIES];
   logic [CTR_BITS-1:0] table_d [ENTRIES];
   logic [15:0]         branch_count_q;
   logic [15:0]         branch_count_d;
   logic [15:0]         mispredict_count_q;
   logic [15:0]         mispredict_count_d;

   // fetch side
   logic [INDEX_BITS-1:0] idx;
   logic                  branch_instr;
   logic [CTR_BITS-1:0]   rd_ctr;
   logic                  predict_taken;
   logic [15:0]           address_taken;

   // writeback side
   logic [INDEX_BITS-1:0] widx;
   logic                  wb_cond;
   logic                  mispredict;
   logic                  update_en;
   logic [CTR_BITS-1:0]   wr_ctr;
   logic [CTR_BITS-1:0]   ctr_upd;

   // Bit 0 of a PC is always zero for aligned instructions, and the upper bits
   // are intentionally dropped (aliasing is accepted).
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.pc[15:INDEX_BITS+1], bus.pc[0],
                             bus.wb_pc[15:INDEX_BITS+1], bus.wb_pc[0]};

   assign idx          = bus.pc[INDEX_BITS:1];
   assign branch_instr = (bus.rom_opcode == OP_BR);
   assign rd_ctr       = table_q[idx];

   // Fetch prediction: BRnzp is always taken, a nop BR never; the rest ask the table.
   always_comb begin
      predict_taken = 1'b0;
      if (branch_instr) begin
         if (bus.nzp == 3'b111) begin
            predict_taken = 1'b1;
         end else if (bus.nzp != 3'b000) begin
            predict_taken = rd_ctr[CTR_BITS-1];
         end
      end
   end

   assign address_taken = predict_taken ? (bus.pc_inc + bus.adj9_out) : bus.pc_inc;

   assign widx       = bus.wb_pc[INDEX_BITS:1];
   assign wb_cond    = bus.wb_valid && (bus.wb_opcode == OP_BR) && (bus.wb_nzp != 3'b000);
   assign mispredict = wb_cond && (bus.branch_enable != bus.wb_pred_taken);
   // BRnzp is never mispredicted, so it neither trains the table nor is counted.
   assign update_en  = !bus.imem_stall && wb_cond && (bus.wb_nzp != 3'b111);
   assign wr_ctr     = table_q[widx];

   // Redirect: a mispredict overrides the fetch-side prediction, even while stalled.
   always_comb begin
      bus.address_out = address_taken;
      if (mispredict) begin
         bus.address_out = bus.branch_enable ? bus.wb_target : bus.wb_pc_plus2;
      end
   end

   assign bus.predict_taken    = predict_taken;
   assign bus.reset_sig        = mispredict;
   assign bus.branch_count     = branch_count_q;
   assign bus.mispredict_count = mispredict_count_q;

   // Saturating step of the resolving branch's counter toward its outcome.
   always_comb begin
      ctr_upd = wr_ctr;
      if (bus.branch_enable) begin
         if (wr_ctr != CTR_MAX) begin
            ctr_upd = wr_ctr + CTR_BITS'(1);
         end
      end else begin
         if (wr_ctr != CTR_ZERO) begin
            ctr_upd = wr_ctr - CTR_BITS'(1);
         end
      end
   end

   // Table next state: only the resolving entry changes; fetch reads table_q (no bypass).
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         table_d[i] = table_q[i];
         if (update_en && (widx == INDEX_BITS'(i))) begin
            table_d[i] = ctr_upd;
         end
      end
   end

   // Performance counters saturate at all-ones rather than wrapping.
   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (update_en) begin
         if (branch_count_q != 16'hFFFF) begin
            branch_count_d = branch_count_q + 16'd1;
         end
         if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
            mispredict_count_d = mispredict_count_q + 16'd1;
         end
      end
   end

   // State registers: reset to the initial counter value and zeroed statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= CTR_INIT;
         end
         branch_count_q     <= 16'd0;
         mispredict_count_q <= 16'd0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= table_d[i];
         end
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Self-checking bench for branch_history_predictor: a behavioural model
// pushes expected outputs into a scoreboard queue as each stimulus is
// driven; the queue is drained against the DUT outputs.
module tb_branch_history_predictor;

   logic clk;
   logic reset;

   branch_history_predictor_if bus ();

   branch_history_predictor #(
      .INDEX_BITS (4),
      .CTR_BITS   (2),
      .RESET_CTR  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          kind;   // 0 predict, 1 address, 2 flush, 3 branch_count, 4 mispredict_count
      logic [15:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          mtab [16];
   logic [15:0] m_bc;
   logic [15:0] m_mc;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] observe(input int kind);
      case (kind)
         0:       return {15'd0, bus.predict_taken};
         1:       return bus.address_out;
         2:       return {15'd0, bus.reset_sig};
         3:       return bus.branch_count;
         default: return bus.mispredict_count;
      endcase
   endfunction

   task automatic drain();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.kind), e.exp);
      end
   endtask

   task automatic push(input string tag, input int kind, input logic [15:0] exp);
      sb_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   // One cycle: drive at negedge, check combinational outputs, clock, check counters.
   task automatic cyc(input string tag, input logic rst, input logic stall,
                      input logic [15:0] pc_i, input logic [3:0] op, input logic [2:0] nzp_i,
                      input logic [15:0] adj, input logic wv, input logic [3:0] wop,
                      input logic [2:0] wnzp, input logic [15:0] wpc, input logic [15:0] wtgt,
                      input logic wpred, input logic ben);
      logic        pred;
      logic        wbc;
      logic        mis;
      logic [15:0] addr;
      int          fi;
      int          wi;
      @(negedge clk);
      reset              = rst;
      bus.imem_stall     = stall;
      bus.rom_opcode     = op;
      bus.nzp            = nzp_i;
      bus.pc             = pc_i;
      bus.pc_inc         = pc_i + 16'd2;
      bus.adj9_out       = adj;
      bus.wb_valid       = wv;
      bus.wb_opcode      = wop;
      bus.wb_nzp         = wnzp;
      bus.wb_pc          = wpc;
      bus.wb_pc_plus2    = wpc + 16'd2;
      bus.wb_target      = wtgt;
      bus.wb_pred_taken  = wpred;
      bus.branch_enable  = ben;

      fi   = int'(pc_i[4:1]);
      wi   = int'(wpc[4:1]);
      pred = 1'b0;
      if (op == 4'b0000) begin
         if (nzp_i == 3'b111)      pred = 1'b1;
         else if (nzp_i != 3'b000) pred = (mtab[fi] >= 2);
      end
      wbc  = wv && (wop == 4'b0000) && (wnzp != 3'b000);
      mis  = wbc && (ben != wpred);
      addr = pred ? (pc_i + 16'd2 + adj) : (pc_i + 16'd2);
      if (mis) addr = ben ? wtgt : (wpc + 16'd2);
      push({tag, ".pred"},  0, {15'd0, pred});
      push({tag, ".addr"},  1, addr);
      push({tag, ".flush"}, 2, {15'd0, mis});
      #1;
      drain();

      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) mtab[i] = 2;
         m_bc = 16'd0;
         m_mc = 16'd0;
      end else if (!stall && wbc && (wnzp != 3'b111)) begin
         if (ben) mtab[wi] = (mtab[wi] == 3) ? 3 : mtab[wi] + 1;
         else     mtab[wi] = (mtab[wi] == 0) ? 0 : mtab[wi] - 1;
         if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
         if (mis && (m_mc != 16'hFFFF)) m_mc = m_mc + 16'd1;
      end
      push({tag, ".bcnt"}, 3, m_bc);
      push({tag, ".mcnt"}, 4, m_mc);
      #1;
      drain();
      $display("txn %-10s pc=%h nzp=%b pred=%b addr=%h flush=%b bc=%0d mc=%0d",
               tag, pc_i, nzp_i, bus.predict_taken, bus.address_out, bus.reset_sig,
               bus.branch_count, bus.mispredict_count);
   endtask

   localparam logic [3:0] BR  = 4'b0000;
   localparam logic [3:0] ADD = 4'b0001;

   initial begin
      for (int i = 0; i < 16; i++) mtab[i] = 0;
      m_bc = 16'd0;
      m_mc = 16'd0;
      reset = 1'b1;
      bus.imem_stall = 1'b0;
      bus.rom_opcode = ADD; bus.nzp = 3'b000; bus.pc = 16'd0; bus.pc_inc = 16'd2;
      bus.adj9_out = 16'd0; bus.wb_valid = 1'b0; bus.wb_opcode = ADD; bus.wb_nzp = 3'b000;
      bus.wb_pc = 16'd0; bus.wb_pc_plus2 = 16'd2; bus.wb_target = 16'd0;
      bus.wb_pred_taken = 1'b0; bus.branch_enable = 1'b0;

      // Reset; a mispredicting WB during reset still flushes but must not train.
      cyc("rst0", 1, 0, 16'h0000, ADD, 3'b000, 16'h0000, 0, ADD, 3'b000, 16'h0000, 16'h0000, 0, 0);
      cyc("rst1", 1, 0, 16'h0010, BR,  3'b010, 16'h0008, 1, BR,  3'b010, 16'h0010, 16'h001A, 1, 0);

      // 1. BRz at 0x0010, weakly taken after reset.
      cyc("t1", 0, 0, 16'h0010, BR, 3'b010, 16'h0008, 0, ADD, 3'b000, 16'h0000, 16'h0000, 0, 0);
      // 2. Two not-taken resolutions with wb_pred_taken=1 -> flush to pc+2 each time.
      cyc("t2a", 0, 0, 16'h0040, ADD, 3'b000, 16'h0000, 1, BR, 3'b010, 16'h0010, 16'h001A, 1, 0);
      cyc("t2b", 0, 0, 16'h0040, ADD, 3'b000, 16'h0000, 1, BR, 3'b010, 16'h0010, 16'h001A, 1, 0);
      cyc("t2c", 0, 0, 16'h0010, BR, 3'b010, 16'h0008, 0, ADD, 3'b000, 16'h0000, 16'h0000, 0, 0);

      // 3. Taken 5x at 0x0020 (idx 0) -> saturates; one not-taken still predicts taken.
      for (int k = 0; k < 5; k++)
         cyc("t3tk", 0, 0, 16'h0020, BR, 3'b100, 16'hFFF0, 1, BR, 3'b100, 16'h0020, 16'h0012, k[0], 1);
      cyc("t3nt", 0, 0, 16'h0020, BR, 3'b100, 16'hFFF0, 1, BR, 3'b100, 16'h0020, 16'h0012, 1, 0);
      cyc("t3rd", 0, 0, 16'h0020, BR, 3'b100, 16'hFFF0, 0, ADD, 3'b000, 16'h0000, 16'h0000, 0, 0);
      cyc("t3nt2", 0, 0, 16'h0022, BR, 3'b001, 16'h0004, 1, BR, 3'b100, 16'h0020, 16'h0012, 1, 0);
      cyc("t3rd2", 0, 0, 16'h0020, BR, 3'b100, 16'hFFF0, 0, ADD, 3'b000, 16'h0000, 16'h0000, 0, 0);

      // 4. Aliasing 0x0030 -> entry of 0x0010; same-cycle fetch reads pre-update value.
      cyc("t4alias", 0, 0, 16'h0030, BR, 3'b011, 16'h0010, 0, ADD, 3'b000, 16'h0000, 16'h0000, 0, 0);
      cyc("t4tk1", 0, 0, 16'h0030, BR, 3'b011, 16'h0010, 1, BR, 3'b011, 16'h0010, 16'h0040, 0, 1);
      cyc("t4same", 0, 0, 16'h0010, BR, 3'b011, 16'h0010, 1, BR, 3'b011, 16'h0030, 16'h0040, 0, 1);
      cyc("t4after", 0, 0, 16'h0010, BR, 3'b011, 16'h0010, 0, ADD, 3'b000, 16'h0000, 16'h0000, 0, 0);

      // 5. Stall with a mispredicting WB: flush visible, nothing updates; then one update.
      for (int k = 0; k < 3; k++)
         cyc("t5stall", 0, 1, 16'h0050, BR, 3'b010, 16'h0006, 1, BR, 3'b010, 16'h0050, 16'h005A, 1, 0);
      cyc("t5go", 0, 0, 16'h0050, BR, 3'b010, 16'h0006, 1, BR, 3'b010, 16'h0050, 16'h005A, 1, 0);
      cyc("t5rd", 0, 0, 16'h0050, BR, 3'b010, 16'h0006, 0, ADD, 3'b000, 16'h0000, 16'h0000, 0, 0);

      // 6. BRnzp and nop BR: predict 1/0, no flush, no training, no counting.
      cyc("t6nzp", 0, 0, 16'h0010, BR, 3'b111, 16'h0100, 1, BR, 3'b111, 16'h0010, 16'h0112, 1, 1);
      cyc("t6nop", 0, 0, 16'h0010, BR, 3'b000, 16'h0100, 1, BR, 3'b000, 16'h0010, 16'h0112, 1, 0);
      cyc("t6rd", 0, 0, 16'h0010, BR, 3'b010, 16'h0100, 0, ADD, 3'b000, 16'h0000, 16'h0000, 0, 0);
      // Non-branch opcode with WB carrying a non-BR opcode.
      cyc("t6add", 0, 0, 16'h0020, ADD, 3'b111, 16'h0100, 1, ADD, 3'b010, 16'h0020, 16'h0122, 1, 0);

      // Branch counter saturation: preload FFFF, then resolve another branch.
      @(negedge clk);
      force dut.branch_count_q = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.branch_count_q;
      m_bc = 16'hFFFF;
      cyc("t6sat", 0, 0, 16'h0060, ADD, 3'b000, 16'h0000, 1, BR, 3'b001, 16'h0060, 16'h0070, 0, 1);
      cyc("t6sat2", 0, 0, 16'h0060, ADD, 3'b000, 16'h0000, 1, BR, 3'b001, 16'h0060, 16'h0070, 1, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
